dual_switch_debounce: RTL and testbench

Two-channel synchronizer and debouncer for raw mechanical switch inputs. It produces clean, registered levels that feed `input_1` and `input_2` of the downstream AND stage, so `and_result` never sees metastability or contact bounce. It also emits single-cycle rise and fall pulses per channel for control logic.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 87 ++++++++
 rtl/dual_switch_debounce.sv | 45 ++++
 tb/tb_dual_switch_debounce.sv | 129 ++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// Each channel runs the same two-state FSM defined here.
package debounce_pkg;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  localparam int DB_DEFAULT_CYCLES = 250000;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, agreement counter and FSM.
// Accepts a new level after DEBOUNCE_CYCLES cycles and emits registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= switch_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (s2_q != out_q) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_PENDING: begin
        // Agreement check comes first so a glitch ending on the last count is still rejected.
        if (s2_q == out_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
          out_d   = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/dual_switch_debounce.sv
// Two independent debounced switch channels feeding the downstream AND stage.
// Every output is a flop inside debounce_channel.
module dual_switch_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_1,
  input  logic switch_2,
  output logic input_1,
  output logic input_2,
  output logic rise_1,
  output logic fall_1,
  output logic rise_2,
  output logic fall_2
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .switch_i(switch_1),
    .level_o (input_1),
    .rise_o  (rise_1),
    .fall_o  (fall_1)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch2 (
    .clk     (clk),
    .rst     (rst),
    .switch_i(switch_2),
    .level_o (input_2),
    .rise_o  (rise_2),
    .fall_o  (fall_2)
  );

endmodule

// File: tb/tb_dual_switch_debounce.sv
// Directed bench for dual_switch_debounce with DEBOUNCE_CYCLES = 4 (6-edge latency).
// Output vector per edge: {input_1, rise_1, fall_1, input_2, rise_2, fall_2}.
module tb_dual_switch_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic switch_1, switch_2;
  logic input_1, input_2;
  logic rise_1, fall_1, rise_2, fall_2;

  int tests_run    = 0;
  int tests_failed = 0;

  dual_switch_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .switch_1(switch_1),
    .switch_2(switch_2),
    .input_1 (input_1),
    .input_2 (input_2),
    .rise_1  (rise_1),
    .fall_1  (fall_1),
    .rise_2  (rise_2),
    .fall_2  (fall_2)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] ALL0   = 6'b000_000;
  localparam logic [5:0] IN1    = 6'b100_000;
  localparam logic [5:0] IN2    = 6'b000_100;
  localparam logic [5:0] IN12   = 6'b100_100;
  localparam logic [5:0] RISE1  = 6'b110_000;
  localparam logic [5:0] RISE2  = 6'b000_110;
  localparam logic [5:0] RISE12 = 6'b110_110;
  localparam logic [5:0] FALL1  = 6'b001_000;

  function automatic logic [5:0] obs();
    return {input_1, rise_1, fall_1, input_2, rise_2, fall_2};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got[5:0], exp[5:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; edges 1..n-1 must show 'quiet', edge n must show 'last'
  task automatic run_edges(input string tag, input int n, input logic [5:0] quiet,
                           input logic [5:0] last);
    for (int i = 1; i <= n; i++) begin
      tick();
      check($sformatf("%s e%0d", tag, i), 32'(obs()), 32'((i == n) ? last : quiet));
    end
  endtask

  initial begin
    rst      = 1'b1;
    switch_1 = 1'b1;
    switch_2 = 1'b1;

    // Reset held with both switches high, then release
    run_edges("reset", 3, ALL0, ALL0);
    rst = 1'b0;
    run_edges("rel_rise", 6, ALL0, RISE12);
    run_edges("rel_hold", 2, IN12, IN12);

    // Return to all-low through reset
    rst      = 1'b1;
    switch_1 = 1'b0;
    switch_2 = 1'b0;
    run_edges("rst2", 2, ALL0, ALL0);
    rst = 1'b0;

    // Bounce on switch_1: toggles every 2 cycles for 20 cycles
    for (int seg = 0; seg < 10; seg++) begin
      switch_1 = (seg % 2 == 0);
      run_edges($sformatf("bounce%0d", seg), 2, ALL0, ALL0);
    end
    switch_1 = 1'b1;
    run_edges("bounce_rise", 6, ALL0, RISE1);
    run_edges("bounce_hold", 3, IN1, IN1);

    // 3-cycle glitch on switch_2
    switch_2 = 1'b1;
    run_edges("glitch_hi", 3, IN1, IN1);
    switch_2 = 1'b0;
    run_edges("glitch_lo", 8, IN1, IN1);

    // Falling edge on switch_1
    switch_1 = 1'b0;
    run_edges("fall", 6, IN1, FALL1);
    run_edges("fall_hold", 2, ALL0, ALL0);

    // Both switches rise together
    switch_1 = 1'b1;
    switch_2 = 1'b1;
    run_edges("simul", 6, ALL0, RISE12);
    check("and_result", 32'(input_1 & input_2), 32'd1);
    run_edges("simul_hold", 2, IN12, IN12);

    // Reset in the middle of a count on switch_2
    rst      = 1'b1;
    switch_1 = 1'b0;
    switch_2 = 1'b0;
    run_edges("rst3", 2, ALL0, ALL0);
    rst      = 1'b0;
    switch_2 = 1'b1;
    run_edges("mid_count", 4, ALL0, ALL0);
    rst = 1'b1;
    run_edges("mid_rst", 2, ALL0, ALL0);
    rst = 1'b0;
    run_edges("mid_rise", 6, ALL0, RISE2);
    run_edges("mid_hold", 2, IN2, IN2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
